uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: LOAD strobe, serializer enable and TX mux select per frame.
// Optional build macro UART_TX_TWO_STOP_EN adds a second stop bit (state STOP2).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       LOAD,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       tx_done
);

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`endif

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] bit_cnt, bit_cnt_nxt;
  logic                 par_en_q, par_en_nxt;
  logic                 load_raw;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      par_en_q <= par_en_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    par_en_nxt  = par_en_q;
    load_raw    = 1'b0;
    mux_sel     = 2'b01;
    ser_en      = 1'b0;
    busy        = 1'b0;
    tx_done     = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          load_raw   = 1'b1;
          par_en_nxt = PAR_EN;
          state_nxt  = START;
        end
      end
      START: begin
        mux_sel     = 2'b00;
        busy        = 1'b1;
        bit_cnt_nxt = '0;
        state_nxt   = DATA;
      end
      DATA: begin
        mux_sel = 2'b10;
        ser_en  = 1'b1;
        busy    = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_nxt = '0;
          state_nxt   = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        mux_sel   = 2'b11;
        busy      = 1'b1;
        state_nxt = STOP;
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP: begin
        busy      = 1'b1;
        state_nxt = STOP2;
      end
      STOP2: begin
        busy    = 1'b1;
        tx_done = 1'b1;
        if (Data_Valid) begin
          load_raw   = 1'b1;
          par_en_nxt = PAR_EN;
          state_nxt  = START;
        end else begin
          state_nxt = IDLE;
        end
      end
`else
      STOP: begin
        busy    = 1'b1;
        tx_done = 1'b1;
        // a new byte here chains the next frame with no idle gap
        if (Data_Valid) begin
          load_raw   = 1'b1;
          par_en_nxt = PAR_EN;
          state_nxt  = START;
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // LOAD stays low while reset is held, even if Data_Valid is asserted
  assign LOAD = load_raw & RST_n;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frames plus random traffic against a frame-position model.
module tb_uart_tx_ctrl;
  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_valid;
  logic       par_en;
  logic       load;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       busy;
  logic       tx_done;

  int vectors = 0;
  int miscompares = 0;

  // model: position within current frame (0 = idle), frame length, latched parity flag
  int pos = 0;
  int flen = 0;
  bit mpar = 1'b0;

  int busy_cnt, ser_cnt, par_cnt, done_cnt, load_cnt;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(3)) dut (
    .clk        (clk),
    .RST_n      (rst_n),
    .Data_Valid (data_valid),
    .PAR_EN     (par_en),
    .LOAD       (load),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mux"},  {6'd0, mux_sel}, 8'h01);
    chk({tag, "_ser"},  {7'd0, ser_en},  8'h00);
    chk({tag, "_busy"}, {7'd0, busy},    8'h00);
    chk({tag, "_done"}, {7'd0, tx_done}, 8'h00);
    chk({tag, "_load"}, {7'd0, load},    8'h00);
  endtask

  task automatic clear_counts();
    busy_cnt = 0; ser_cnt = 0; par_cnt = 0; done_cnt = 0; load_cnt = 0;
  endtask

  // one clock: drive inputs at negedge, check against model, advance model
  task automatic step(input logic dv, input logic pe);
    logic [1:0] e_mux;
    logic e_ser, e_busy, e_done, e_load;
    @(negedge clk);
    data_valid = dv;
    par_en     = pe;
    #1;
    e_load = dv && (pos == 0 || pos == flen);
    e_ser  = 1'b0;
    e_done = 1'b0;
    e_busy = (pos != 0);
    if (pos == 0)                     e_mux = 2'b01;
    else if (pos == 1)                e_mux = 2'b00;
    else if (pos <= DW + 1) begin     e_mux = 2'b10; e_ser = 1'b1; end
    else if (mpar && pos == DW + 2)   e_mux = 2'b11;
    else begin                        e_mux = 2'b01; e_done = (pos == flen); end
    chk("mux_sel", {6'd0, mux_sel}, {6'd0, e_mux});
    chk("ser_en",  {7'd0, ser_en},  {7'd0, e_ser});
    chk("busy",    {7'd0, busy},    {7'd0, e_busy});
    chk("tx_done", {7'd0, tx_done}, {7'd0, e_done});
    chk("load",    {7'd0, load},    {7'd0, e_load});
    busy_cnt += int'(busy === 1'b1);
    ser_cnt  += int'(ser_en === 1'b1);
    par_cnt  += int'(mux_sel === 2'b11);
    done_cnt += int'(tx_done === 1'b1);
    load_cnt += int'(load === 1'b1);
    if (e_load) begin
      pos  = 1;
      mpar = pe;
      flen = 1 + DW + int'(pe) + NSTOP;
    end else if (pos != 0) begin
      pos = (pos == flen) ? 0 : pos + 1;
    end
  endtask

  task automatic check_frame(input string tag, input int frames, input logic pe);
    chk({tag, "_busy_cycles"}, 8'(busy_cnt), 8'(frames * (1 + DW + int'(pe) + NSTOP)));
    chk({tag, "_ser_cycles"},  8'(ser_cnt),  8'(frames * DW));
    chk({tag, "_par_cycles"},  8'(par_cnt),  8'(frames * int'(pe)));
    chk({tag, "_done_cycles"}, 8'(done_cnt), 8'(frames));
    chk({tag, "_loads"},       8'(load_cnt), 8'(frames));
  endtask

  task automatic single_frame(input string tag, input logic pe);
    clear_counts();
    step(1'b1, pe);
    repeat (DW + 6) step(1'b0, pe);
    check_frame(tag, 1, pe);
  endtask

  initial begin
    rst_n = 1'b0;
    data_valid = 1'b0;
    par_en = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    single_frame("frame_par1", 1'b1);
    single_frame("frame_par0", 1'b0);

    // back-to-back: Data_Valid held high across two full frames
    clear_counts();
    repeat (2 * (1 + DW + 1 + NSTOP)) step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    check_frame("b2b", 2, 1'b1);

    // request during DATA ignored; PAR_EN change mid-frame has no effect
    clear_counts();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (DW + 4) step(1'b0, 1'b0);
    check_frame("ignored_req", 1, 1'b1);

    // async reset in DATA with bit_cnt = 3
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    #1 rst_n = 1'b0;
    data_valid = 1'b1;
    #1;
    chk_reset_outputs("midframe_reset");
    data_valid = 1'b0;
    pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    single_frame("after_reset", 1'b1);

    // random traffic
    repeat (1500) step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    repeat (DW + 6) step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
